// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows on 16-byte column-major states.
// Two ping-pong banks let one state fill while the other drains.
module inv_shift_rows_stream (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last
);

  logic [7:0] mem_q [2][16];

  logic [1:0] full_q;
  logic [1:0] full_d;
  logic [3:0] wcnt_q;
  logic [3:0] wcnt_d;
  logic [3:0] rcnt_q;
  logic [3:0] rcnt_d;
  logic       wptr_q;
  logic       wptr_d;
  logic       rptr_q;
  logic       rptr_d;

  logic       wr_fire;
  logic       rd_fire;
  logic       wr_end;
  logic       rd_end;
  logic [1:0] rd_col;
  logic [1:0] rd_row;
  logic [1:0] src_col;
  logic [3:0] src_idx;
  logic [7:0] rd_byte;

  // Source byte for output index 4c+r comes from column (c-r) mod 4.
  always_comb begin
    rd_col  = rcnt_q[3:2];
    rd_row  = rcnt_q[1:0];
    src_col = rd_col - rd_row;
    src_idx = {src_col, rd_row};
    rd_byte = mem_q[rptr_q][src_idx];
  end

  // Handshake decode and output gating.
  always_comb begin
    in_ready  = !full_q[wptr_q];
    out_valid = full_q[rptr_q];
    wr_fire   = in_valid && in_ready;
    rd_fire   = out_valid && out_ready;
    wr_end    = wr_fire && (wcnt_q == 4'd15);
    rd_end    = rd_fire && (rcnt_q == 4'd15);
    out_byte  = out_valid ? rd_byte : 8'h00;
    out_last  = out_valid && (rcnt_q == 4'd15);
  end

  // Next-state for counters, pointers and full flags.
  // Fill and drain always target different banks, so both
  // flag updates can be applied in the same cycle.
  always_comb begin
    full_d = full_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_fire) begin
      wcnt_d = wcnt_q + 4'd1;
    end
    if (wr_end) begin
      full_d[wptr_q] = 1'b1;
      wptr_d         = !wptr_q;
    end
    if (rd_fire) begin
      rcnt_d = rcnt_q + 4'd1;
    end
    if (rd_end) begin
      full_d[rptr_q] = 1'b0;
      rptr_d         = !rptr_q;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 2'b00;
      wcnt_q <= 4'd0;
      rcnt_q <= 4'd0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      full_q <= full_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Bank storage; contents are don't-care until the bank is full.
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) begin
      mem_q[wptr_q][wcnt_q] <= in_byte;
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Directed bench for inv_shift_rows_stream.
// Table of states with hand-computed results plus corner sequences.
module tb_inv_shift_rows_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;

  inv_shift_rows_stream dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_byte  (in_byte),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .out_last (out_last)
  );

  always #5 clk = !clk;

  typedef struct {
    logic [0:15][7:0] din;
    logic [0:15][7:0] dexp;
  } vec_t;

  vec_t tbl [4];

  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;

  int cyc = 0;
  int in_cnt = 0;
  int in_block = 0;
  int last_in_cyc = 0;
  int first_out_cyc = 0;
  logic [7:0] out_q [$];
  bit         last_q [$];
  int         cyc_q [$];

  bit         prev_stall = 0;
  logic [7:0] prev_byte = 8'h00;
  logic       prev_last = 1'b0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic clear_mon();
    out_q.delete();
    last_q.delete();
    cyc_q.delete();
    in_cnt = 0;
    in_block = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (in_valid && in_ready) begin
          in_cnt++;
          last_in_cyc = cyc;
        end
        if (in_valid && !in_ready) in_block++;
        if (!out_valid) begin
          chk("idle_byte", 32'(out_byte), 32'h0);
          chk("idle_last", 32'(out_last), 32'h0);
        end
        if (prev_stall) begin
          chk("stall_valid", 32'(out_valid), 32'h1);
          chk("stall_byte", 32'(out_byte), 32'(prev_byte));
          chk("stall_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && out_ready) begin
          if (out_q.size() == 0) first_out_cyc = cyc;
          out_q.push_back(out_byte);
          last_q.push_back(out_last);
          cyc_q.push_back(cyc);
        end
        prev_stall = out_valid && !out_ready;
        prev_byte  = out_byte;
        prev_last  = out_last;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(logic [7:0] b);
    bit done = 0;
    in_valid = 1'b1;
    in_byte  = b;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      sync();
    end
    if (!done) chk("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic send_state(int v);
    for (int k = 0; k < 16; k++) send_byte(tbl[v].din[k]);
  endtask

  task automatic wait_outputs(int n);
    int t = 0;
    while (out_q.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (out_q.size() < n) chk("out_timeout", 32'(out_q.size()), 32'(n));
  endtask

  task automatic check_state(int base, int v, string nm);
    for (int j = 0; j < 16; j++) begin
      chk({nm, "_byte"}, 32'(out_q[base+j]), 32'(tbl[v].dexp[j]));
      chk({nm, "_last"}, 32'(last_q[base+j]), 32'(j == 15));
    end
  endtask

  task automatic check_rows(int base, int v);
    int bad = 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (out_q[base + 4*((c+r)%4) + r] !== tbl[v].din[4*c+r]) bad++;
    chk("shiftrows_inverse", 32'(bad), 32'h0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    sync();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic check_reset(string nm);
    @(negedge clk);
    chk({nm, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({nm, "_out_last"}, 32'(out_last), 32'h0);
    chk({nm, "_out_byte"}, 32'(out_byte), 32'h0);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'h1);
  endtask

  initial begin
    tbl[0].din  = 128'h000102030405060708090A0B0C0D0E0F;
    tbl[0].dexp = 128'h000D0A0704010E0B0805020F0C090603;
    tbl[1].din  = 128'h101112131415161718191A1B1C1D1E1F;
    tbl[1].dexp = 128'h101D1A1714111E1B1815121F1C191613;
    tbl[2].din  = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;
    tbl[2].dexp = 128'hFFF2F5F8FBFEF1F4F7FAFDF0F3F6F9FC;
    tbl[3].din  = 128'h00112233445566778899AABBCCDDEEFF;
    tbl[3].dexp = 128'h00DDAA774411EEBB885522FFCC996633;

    rst = 1'b1;
    in_valid = 1'b0;
    in_byte = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("reset");

    // Single state, latency and out_last position.
    clear_mon();
    sync();
    send_state(0);
    in_valid = 1'b0;
    wait_outputs(16);
    chk("latency", 32'(first_out_cyc - last_in_cyc), 32'h1);
    check_state(0, 0, "single");
    check_rows(0, 0);

    // All table states back to back at full rate.
    clear_mon();
    sync();
    for (int v = 0; v < 4; v++) send_state(v);
    in_valid = 1'b0;
    wait_outputs(64);
    for (int v = 0; v < 4; v++) begin
      check_state(16*v, v, "b2b");
      check_rows(16*v, v);
    end
    begin
      int gaps = 0;
      for (int i = 0; i < 64; i++)
        if (cyc_q[i] != cyc_q[0] + i) gaps++;
      chk("b2b_bubbles", 32'(gaps), 32'h0);
      chk("b2b_in_block", 32'(in_block), 32'h0);
    end

    // Downstream stalled for 40 cycles while three states arrive.
    rdy_mode = 2;
    sync();
    sync();
    clear_mon();
    fork
      begin
        send_state(0);
        send_state(1);
        send_state(2);
        in_valid = 1'b0;
      end
      begin
        repeat (40) @(negedge clk);
        chk("stall_in_cnt", 32'(in_cnt), 32'd32);
        chk("stall_in_ready", 32'(in_ready), 32'h0);
        chk("stall_out_valid", 32'(out_valid), 32'h1);
        chk("stall_out_byte", 32'(out_byte), 32'h0);
        chk("stall_no_out", 32'(out_q.size()), 32'h0);
        rdy_mode = 0;
      end
    join
    wait_outputs(48);
    for (int v = 0; v < 3; v++) check_state(16*v, v, "stall");

    // Random downstream backpressure.
    rdy_mode = 1;
    clear_mon();
    sync();
    send_state(3);
    send_state(1);
    in_valid = 1'b0;
    wait_outputs(32);
    check_state(0, 3, "rand0");
    check_state(16, 1, "rand1");
    rdy_mode = 0;
    repeat (4) sync();

    // Reset after a partial fill, then a clean state.
    clear_mon();
    for (int k = 0; k < 7; k++) send_byte(tbl[2].din[k]);
    do_reset();
    check_reset("midrst");
    sync();
    send_state(0);
    in_valid = 1'b0;
    wait_outputs(16);
    repeat (20) @(negedge clk);
    chk("midrst_count", 32'(out_q.size()), 32'd16);
    check_state(0, 0, "midrst");

    // Reset during a partial drain.
    rdy_mode = 2;
    sync();
    clear_mon();
    send_state(1);
    in_valid = 1'b0;
    rdy_mode = 1;
    repeat (12) sync();
    rdy_mode = 0;
    do_reset();
    check_reset("drainrst");
    sync();
    send_state(3);
    in_valid = 1'b0;
    wait_outputs(16);
    repeat (20) @(negedge clk);
    chk("drainrst_count", 32'(out_q.size()), 32'd16);
    check_state(0, 3, "drainrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
